// File: rtl/rgb_to_yuv_converter.sv
// Converts one 8-bit RGB pixel to BT.601 studio-range 8-bit Y/U/V using three shared signed Q16 MACs.
// Latency: a pixel accepted on edge N is presented with out_valid=1 after edge N+3. Peak rate is one pixel every 4 cycles.
// Backpressure: the result holds in OUT until out_ready; in_ready is high only in IDLE, or in OUT while out_ready is high.
module rgb_to_yuv_converter #(
    parameter int COEFF_FRAC = 16,
    parameter int CLIP_EN    = 1
) (
    input  logic       CLOCK_50_I,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] R_in,
    input  logic [7:0] G_in,
    input  logic [7:0] B_in,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] Y_out,
    output logic [7:0] U_out,
    output logic [7:0] V_out,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MUL_R = 3'd1,
        MUL_G = 3'd2,
        MUL_B = 3'd3,
        OUT   = 3'd4
    } state_t;

    // Rounding constant is half an LSB of the final shift, so the floor shift rounds to nearest.
    localparam logic signed [31:0] RND_HALF  = 32'sd1 <<< (COEFF_FRAC - 1);
    localparam logic signed [31:0] Y_PRESET  = (32'sd16  <<< COEFF_FRAC) + RND_HALF;
    localparam logic signed [31:0] UV_PRESET = (32'sd128 <<< COEFF_FRAC) + RND_HALF;

    // BT.601 studio-range coefficients in Q16 (value * 65536).
    localparam logic signed [31:0] C_Y_R =  32'sd16829;
    localparam logic signed [31:0] C_Y_G =  32'sd33039;
    localparam logic signed [31:0] C_Y_B =  32'sd6416;
    localparam logic signed [31:0] C_U_R = -32'sd9714;
    localparam logic signed [31:0] C_U_G = -32'sd19070;
    localparam logic signed [31:0] C_U_B =  32'sd28784;
    localparam logic signed [31:0] C_V_R =  32'sd28784;
    localparam logic signed [31:0] C_V_G = -32'sd24103;
    localparam logic signed [31:0] C_V_B = -32'sd4681;

    state_t state;
    state_t state_nxt;

    logic [7:0] r_q;
    logic [7:0] g_q;
    logic [7:0] b_q;

    logic signed [31:0] y_acc;
    logic signed [31:0] u_acc;
    logic signed [31:0] v_acc;

    logic        [7:0]  operand;
    logic signed [31:0] coef_y;
    logic signed [31:0] coef_u;
    logic signed [31:0] coef_v;
    logic signed [31:0] operand_s;
    logic signed [31:0] prod_y;
    logic signed [31:0] prod_u;
    logic signed [31:0] prod_v;
    logic signed [31:0] y_sum;
    logic signed [31:0] u_sum;
    logic signed [31:0] v_sum;

    logic accept;
    logic in_mul;

    // Drop the fractional bits (floor) and either saturate to 0..255 or wrap to the low byte.
    function automatic logic [7:0] round_clip(input logic signed [31:0] acc);
        logic signed [31:0] res;
        res = acc >>> COEFF_FRAC;
        if (CLIP_EN != 0) begin
            if (res < 32'sd0) begin
                return 8'd0;
            end
            if (res > 32'sd255) begin
                return 8'd255;
            end
        end
        return res[7:0];
    endfunction

    // A new pixel may enter when idle, or when the held result leaves on the same edge.
    assign in_ready  = (state == IDLE) | ((state == OUT) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state == OUT);
    assign busy      = (state != IDLE);
    assign in_mul    = (state == MUL_R) | (state == MUL_G) | (state == MUL_B);

    // State register.
    always_ff @(posedge CLOCK_50_I) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: three fixed MAC steps, then wait in OUT for the consumer.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = MUL_R;
                end
            end
            MUL_R: state_nxt = MUL_G;
            MUL_G: state_nxt = MUL_B;
            MUL_B: state_nxt = OUT;
            OUT: begin
                if (out_ready) begin
                    state_nxt = in_valid ? MUL_R : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand and coefficient select: each state feeds one colour component to all three MACs.
    always_comb begin
        operand = 8'd0;
        coef_y  = 32'sd0;
        coef_u  = 32'sd0;
        coef_v  = 32'sd0;
        case (state)
            MUL_R: begin
                operand = r_q;
                coef_y  = C_Y_R;
                coef_u  = C_U_R;
                coef_v  = C_V_R;
            end
            MUL_G: begin
                operand = g_q;
                coef_y  = C_Y_G;
                coef_u  = C_U_G;
                coef_v  = C_V_G;
            end
            MUL_B: begin
                operand = b_q;
                coef_y  = C_Y_B;
                coef_u  = C_U_B;
                coef_v  = C_V_B;
            end
            default: begin
                operand = 8'd0;
            end
        endcase
    end

    // Operand is unsigned 8-bit; zero-extend before the signed multiply so it never reads as negative.
    assign operand_s = $signed({24'd0, operand});
    assign prod_y    = coef_y * operand_s;
    assign prod_u    = coef_u * operand_s;
    assign prod_v    = coef_v * operand_s;
    assign y_sum     = y_acc + prod_y;
    assign u_sum     = u_acc + prod_u;
    assign v_sum     = v_acc + prod_v;

    // Input capture and accumulator update; accept only happens in IDLE/OUT, so it never collides with a MAC step.
    always_ff @(posedge CLOCK_50_I) begin
        if (reset) begin
            r_q   <= 8'd0;
            g_q   <= 8'd0;
            b_q   <= 8'd0;
            y_acc <= 32'sd0;
            u_acc <= 32'sd0;
            v_acc <= 32'sd0;
        end else if (accept) begin
            r_q   <= R_in;
            g_q   <= G_in;
            b_q   <= B_in;
            y_acc <= Y_PRESET;
            u_acc <= UV_PRESET;
            v_acc <= UV_PRESET;
        end else if (in_mul) begin
            y_acc <= y_sum;
            u_acc <= u_sum;
            v_acc <= v_sum;
        end
    end

    // Output registers: written once on the last MAC step and held otherwise, including while stalled.
    always_ff @(posedge CLOCK_50_I) begin
        if (reset) begin
            Y_out <= 8'd0;
            U_out <= 8'd0;
            V_out <= 8'd0;
        end else if (state == MUL_B) begin
            Y_out <= round_clip(y_sum);
            U_out <= round_clip(u_sum);
            V_out <= round_clip(v_sum);
        end
    end

endmodule

// File: tb/tb_rgb_to_yuv_converter.sv
// Scoreboard bench for rgb_to_yuv_converter: directed colours, backpressure, streaming, reset, random sweep.
// Expected Y/U/V come from plain integer BT.601 Q16 formulas pushed when a pixel is accepted.
// A negedge monitor pops and compares on every out_valid & out_ready transfer and checks stall stability.
module tb_rgb_to_yuv_converter;

    typedef struct {
        int y;
        int u;
        int v;
    } yuv_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] R_in = 8'd0;
    logic [7:0] G_in = 8'd0;
    logic [7:0] B_in = 8'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] Y_out;
    logic [7:0] U_out;
    logic [7:0] V_out;
    logic       busy;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    yuv_t sb[$];

    bit   rdy_random = 1'b0;
    bit   rdy_force = 1'b1;

    int   acc_cyc;
    bit   acc_ov;

    bit         prev_stall = 1'b0;
    logic [7:0] prev_y;
    logic [7:0] prev_u;
    logic [7:0] prev_v;

    rgb_to_yuv_converter #(
        .COEFF_FRAC(16),
        .CLIP_EN(1)
    ) dut (
        .CLOCK_50_I(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .R_in(R_in),
        .G_in(G_in),
        .B_in(B_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .Y_out(Y_out),
        .U_out(U_out),
        .V_out(V_out),
        .busy(busy)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer: either a fixed out_ready level or a random one (ready 3 cycles in 4).
    always @(posedge clk) begin
        #1;
        if (rdy_random) out_ready = ($urandom_range(3) != 0);
        else            out_ready = rdy_force;
    end

    // Reference: Y = 16 + (0.257R + 0.504G + 0.098B), U/V = 128 + ..., all in Q16 with round-half-up then floor.
    function automatic yuv_t ref_yuv(input int r, input int g, input int b);
        yuv_t e;
        e.y = (16 * 65536 + 32768 + 16829 * r + 33039 * g + 6416 * b) >>> 16;
        e.u = (128 * 65536 + 32768 - 9714 * r - 19070 * g + 28784 * b) >>> 16;
        e.v = (128 * 65536 + 32768 + 28784 * r - 24103 * g - 4681 * b) >>> 16;
        if (e.y < 0) e.y = 0; else if (e.y > 255) e.y = 255;
        if (e.u < 0) e.u = 0; else if (e.u > 255) e.u = 255;
        if (e.v < 0) e.v = 0; else if (e.v > 255) e.v = 255;
        return e;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every transfer against the scoreboard; a stalled result must not move.
    always @(negedge clk) begin
        yuv_t e;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", int'(out_valid), 1);
                check("stall_y", int'(Y_out), int'(prev_y));
                check("stall_u", int'(U_out), int'(prev_u));
                check("stall_v", int'(V_out), int'(prev_v));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("y_out", int'(Y_out), e.y);
                    check("u_out", int'(U_out), e.u);
                    check("v_out", int'(V_out), e.v);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_y = Y_out;
            prev_u = U_out;
            prev_v = V_out;
        end
    end

    // Present a pixel and hold it until accepted; in_valid stays high so callers can stream back-to-back.
    task automatic send_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        bit done;
        done = 1'b0;
        R_in = r;
        G_in = g;
        B_in = b;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(ref_yuv(int'(r), int'(g), int'(b)));
                acc_cyc = cyc;
                acc_ov = out_valid;
                done = 1'b1;
            end
            tick();
        end
        if (!done) check("accept_timeout", 0, 1);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid) break;
            n++;
        end
        if (!out_valid) check("valid_timeout", 0, 1);
        tick();
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400 && sb.size() != 0; i++) tick();
        check("scoreboard_drained", sb.size(), 0);
    endtask

    task automatic do_reset_and_check(input string tag);
        reset = 1'b1;
        sb.delete();
        tick();
        reset = 1'b0;
        @(negedge clk);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_in_ready"}, int'(in_ready), 1);
        check({tag, "_yuv_zero"}, int'({Y_out, U_out, V_out}), 0);
        tick();
    endtask

    initial begin
        int n;
        int last;
        logic [7:0] hy;
        logic [7:0] hu;
        logic [7:0] hv;

        // Reset state
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_yuv_zero", int'({Y_out, U_out, V_out}), 0);
        tick();

        // Directed colours with latency of the first one
        rdy_force = 1'b1;
        send_pixel(8'd0, 8'd0, 8'd0);
        in_valid = 1'b0;
        check("busy_after_accept", int'(busy), 1);
        wait_valid(n);
        check("latency_edges", n, 3);
        send_pixel(8'd255, 8'd255, 8'd255);
        in_valid = 1'b0;
        wait_drain();
        send_pixel(8'd255, 8'd0, 8'd0);
        in_valid = 1'b0;
        wait_drain();
        send_pixel(8'd0, 8'd0, 8'd255);
        in_valid = 1'b0;
        wait_drain();
        check("white_ref_y", ref_yuv(255, 255, 255).y, 235);
        check("red_ref_v", ref_yuv(255, 0, 0).v, 240);

        // Backpressure: result held for 10 cycles, a new pixel is refused, one transfer on release
        rdy_force = 1'b0;
        repeat (2) tick();
        send_pixel(8'd255, 8'd0, 8'd0);
        in_valid = 1'b0;
        wait_valid(n);
        hy = Y_out;
        hu = U_out;
        hv = V_out;
        R_in = 8'd10;
        G_in = 8'd200;
        B_in = 8'd30;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_hold", int'({Y_out, U_out, V_out}), int'({hy, hu, hv}));
            tick();
        end
        in_valid = 1'b0;
        rdy_force = 1'b1;
        tick();
        rdy_force = 1'b0;
        tick();
        @(negedge clk);
        check("bp_single_transfer", sb.size(), 0);
        check("bp_idle_after", int'(busy), 0);
        tick();
        rdy_force = 1'b1;
        repeat (8) tick();

        // Streaming red/blue with in_valid and out_ready held high
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) send_pixel(8'd255, 8'd0, 8'd0);
            else            send_pixel(8'd0, 8'd0, 8'd255);
            if (i > 0) begin
                check("stream_interval", acc_cyc - last, 4);
                check("stream_simul_handshake", int'(acc_ov), 1);
            end
            last = acc_cyc;
        end
        in_valid = 1'b0;
        wait_drain();

        // Reset during MUL_G
        send_pixel(8'd100, 8'd150, 8'd200);
        in_valid = 1'b0;
        tick();
        do_reset_and_check("rst_mulg");
        send_pixel(8'd0, 8'd0, 8'd0);
        in_valid = 1'b0;
        wait_drain();

        // Reset while stalled in OUT
        rdy_force = 1'b0;
        repeat (2) tick();
        send_pixel(8'd0, 8'd0, 8'd255);
        in_valid = 1'b0;
        wait_valid(n);
        repeat (3) tick();
        do_reset_and_check("rst_out");
        rdy_force = 1'b1;
        send_pixel(8'd0, 8'd0, 8'd0);
        in_valid = 1'b0;
        wait_drain();

        // Random sweep with random consumer stalls and gaps on the source side
        rdy_random = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            send_pixel(8'($urandom_range(255)), 8'($urandom_range(255)), 8'($urandom_range(255)));
            if ($urandom_range(7) == 0) begin
                in_valid = 1'b0;
                tick();
            end
        end
        in_valid = 1'b0;
        rdy_random = 1'b0;
        rdy_force = 1'b1;
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
